// File: rtl/mux_scan_reg_pkg.sv
// Shared mode encodings and width helper for the registered scan multiplexer.
// Combinational definitions only; no latency, no flow control.
package mux_scan_reg_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // A counter over n states needs at least one bit even when n == 1.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_scan_reg_if.sv
// Input/output bundle of the scan multiplexer; master drives selection and data, slave returns results.
// Wires only: no latency and no backpressure (en is a pure sample gate).
interface mux_scan_reg_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
);
  localparam int SELW = $clog2(NCH);

  logic                   en;
  logic                   mode;
  logic [SELW-1:0]        sel;
  logic [NCH*WIDTH-1:0]   m_in;
  logic [WIDTH-1:0]       m_out;
  logic [SELW-1:0]        m_ch;
  logic                   m_valid;
  logic                   sel_err;
  logic                   scan_wrap;

  modport master (
    output en, mode, sel, m_in,
    input  m_out, m_ch, m_valid, sel_err, scan_wrap
  );

  modport slave (
    input  en, mode, sel, m_in,
    output m_out, m_ch, m_valid, sel_err, scan_wrap
  );

endinterface

// File: rtl/mux_scan_reg_ctr.sv
// Scan pointer/dwell counters with restart on any mode change; o_ptr/o_last describe the current sample.
// Counters advance one edge after an enabled scan sample; i_en low holds them (no backpressure).
module mux_scan_reg_ctr
  import mux_scan_reg_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DWELL = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic                    i_mode,
  output logic [$clog2(NCH)-1:0]  o_ptr,
  output logic                    o_last
);

  localparam int SELW = $clog2(NCH);
  localparam int DW   = clog2_min1(DWELL);
  localparam logic [SELW-1:0] P_LAST = SELW'(NCH - 1);
  localparam logic [DW-1:0]   D_LAST = DW'(DWELL - 1);

  logic            r_mode_q;
  logic [SELW-1:0] r_p;
  logic [DW-1:0]   r_d;

  logic            w_restart;
  logic [SELW-1:0] w_p;
  logic [DW-1:0]   w_d;
  logic            w_dwell_done;

  // A mode flip this cycle makes the counters read as zero, so scan entry starts clean.
  assign w_restart    = (i_mode != r_mode_q);
  assign w_p          = w_restart ? '0 : r_p;
  assign w_d          = w_restart ? '0 : r_d;
  assign w_dwell_done = (w_d == D_LAST);

  assign o_ptr  = w_p;
  assign o_last = (w_p == P_LAST) && w_dwell_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_q <= MODE_MANUAL;
      r_p      <= '0;
      r_d      <= '0;
    end else begin
      r_mode_q <= i_mode;
      if (i_mode != MODE_SCAN) begin
        r_p <= '0;
        r_d <= '0;
      end else if (i_en) begin
        if (w_dwell_done) begin
          r_d <= '0;
          r_p <= (w_p == P_LAST) ? '0 : w_p + 1'b1;
        end else begin
          r_d <= w_d + 1'b1;
          r_p <= w_p;
        end
      end else begin
        r_p <= w_p;
        r_d <= w_d;
      end
    end
  end

endmodule

// File: rtl/mux_scan_reg.sv
// Registered N-channel W-bit mux with manual select or timed scan of all channels.
// 1-cycle latency, all outputs registered; en low freezes data/state and drops m_valid (no backpressure).
module mux_scan_reg
  import mux_scan_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int DWELL = 1
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_reg_if.slave  bus
);

  localparam int SELW = $clog2(NCH);

  logic [SELW-1:0]  w_ptr;
  logic             w_last;
  logic [SELW-1:0]  w_idx;
  logic [WIDTH-1:0] w_dat;
  logic             w_sel_ok;

  logic [WIDTH-1:0] r_out;
  logic [SELW-1:0]  r_ch;
  logic             r_valid;
  logic             r_err;
  logic             r_wrap;

  mux_scan_reg_ctr #(
    .NCH   (NCH),
    .DWELL (DWELL)
  ) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_en   (bus.en),
    .i_mode (bus.mode),
    .o_ptr  (w_ptr),
    .o_last (w_last)
  );

  assign w_idx    = (bus.mode == MODE_SCAN) ? w_ptr : bus.sel;
  assign w_sel_ok = (int'(bus.sel) < NCH);

  // Explicit compare-and-pick so an out-of-range manual select never slices past m_in.
  always_comb begin
    w_dat = '0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(w_idx) == k) w_dat = bus.m_in[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (!bus.en) begin
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (bus.mode == MODE_SCAN) begin
      r_out   <= w_dat;
      r_ch    <= w_ptr;
      r_valid <= 1'b1;
      r_err   <= 1'b0;
      r_wrap  <= w_last;
    end else begin
      r_ch    <= bus.sel;
      r_wrap  <= 1'b0;
      r_out   <= w_sel_ok ? w_dat : '0;
      r_valid <= w_sel_ok;
      r_err   <= !w_sel_ok;
    end
  end

  assign bus.m_out     = r_out;
  assign bus.m_ch      = r_ch;
  assign bus.m_valid   = r_valid;
  assign bus.sel_err   = r_err;
  assign bus.scan_wrap = r_wrap;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Two instances (4 ch / dwell 2, 3 ch / dwell 3) driven in lockstep and compared each edge
// against a model that tracks scan position as a count of enabled scan samples.
module tb_mux_scan_reg;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic mode;
  logic [1:0] sel;
  logic [3:0] cha [4];
  logic [3:0] chb [3];

  always #5 clk = ~clk;

  mux_scan_reg_if #(.WIDTH(4), .NCH(4)) if_a ();
  mux_scan_reg_if #(.WIDTH(4), .NCH(3)) if_b ();

  assign if_a.en   = en;
  assign if_a.mode = mode;
  assign if_a.sel  = sel;
  assign if_a.m_in = {cha[3], cha[2], cha[1], cha[0]};
  assign if_b.en   = en;
  assign if_b.mode = mode;
  assign if_b.sel  = sel;
  assign if_b.m_in = {chb[2], chb[1], chb[0]};

  mux_scan_reg #(.WIDTH(4), .NCH(4), .DWELL(2)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  mux_scan_reg #(.WIDTH(4), .NCH(3), .DWELL(3)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  int checks = 0;
  int passed = 0;

  int nch [2] = '{4, 3};
  int dw  [2] = '{2, 3};
  int t   [2];
  logic pm;
  logic [3:0] e_out [2];
  logic [1:0] e_ch  [2];
  logic       e_v   [2];
  logic       e_err [2];
  logic       e_w   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] chdat(input int i, input int k);
    if (i == 0) return cha[k];
    return (k < 3) ? chb[k] : 4'h0;
  endfunction

  task automatic step(input string tag);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        t[i] = 0; e_out[i] = '0; e_ch[i] = '0;
        e_v[i] = 1'b0; e_err[i] = 1'b0; e_w[i] = 1'b0;
      end else begin
        if (mode != pm || !mode) t[i] = 0;
        if (!en) begin
          e_v[i] = 1'b0; e_w[i] = 1'b0;
        end else if (mode) begin
          int c;
          c = (t[i] / dw[i]) % nch[i];
          e_ch[i]  = 2'(c);
          e_out[i] = chdat(i, c);
          e_v[i]   = 1'b1;
          e_err[i] = 1'b0;
          e_w[i]   = ((t[i] % (nch[i] * dw[i])) == nch[i] * dw[i] - 1);
          t[i]     = (t[i] + 1) % (nch[i] * dw[i]);
        end else begin
          e_w[i]  = 1'b0;
          e_ch[i] = sel;
          if (int'(sel) < nch[i]) begin
            e_out[i] = chdat(i, int'(sel)); e_v[i] = 1'b1; e_err[i] = 1'b0;
          end else begin
            e_out[i] = '0; e_v[i] = 1'b0; e_err[i] = 1'b1;
          end
        end
      end
    end
    pm = rst ? 1'b0 : mode;
    @(posedge clk);
    #1;
    chk({tag, "/a.out"},   32'(if_a.m_out),     32'(e_out[0]));
    chk({tag, "/a.ch"},    32'(if_a.m_ch),      32'(e_ch[0]));
    chk({tag, "/a.valid"}, 32'(if_a.m_valid),   32'(e_v[0]));
    chk({tag, "/a.err"},   32'(if_a.sel_err),   32'(e_err[0]));
    chk({tag, "/a.wrap"},  32'(if_a.scan_wrap), 32'(e_w[0]));
    chk({tag, "/b.out"},   32'(if_b.m_out),     32'(e_out[1]));
    chk({tag, "/b.ch"},    32'(if_b.m_ch),      32'(e_ch[1]));
    chk({tag, "/b.valid"}, 32'(if_b.m_valid),   32'(e_v[1]));
    chk({tag, "/b.err"},   32'(if_b.sel_err),   32'(e_err[1]));
    chk({tag, "/b.wrap"},  32'(if_b.scan_wrap), 32'(e_w[1]));
  endtask

  initial begin
    cha[0] = 4'hF; cha[1] = 4'hA; cha[2] = 4'h5; cha[3] = 4'h3;
    chb[0] = 4'hF; chb[1] = 4'hA; chb[2] = 4'h5;
    t[0] = 0; t[1] = 0; pm = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_out[i] = '0; e_ch[i] = '0; e_v[i] = 1'b0; e_err[i] = 1'b0; e_w[i] = 1'b0;
    end
    rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 2'd0;

    // Reset with scan requested, then first scan sample on ch0.
    step("rst0");
    step("rst1");
    rst = 1'b0;
    step("rst_release");

    // Manual select.
    mode = 1'b0; sel = 2'd0;
    step("man_sel0");
    sel = 2'd1;
    step("man_sel1");

    // Out-of-range select on the 3-channel instance, then back in range.
    sel = 2'd3;
    step("range_bad");
    sel = 2'd2;
    step("range_ok");

    // Full scan cycle plus one; wrap on the last dwell of the last channel.
    mode = 1'b1;
    for (int k = 0; k < 9; k++) step("scan");

    // Hold mid-dwell at ch2 then resume.
    for (int k = 0; k < 20 && e_ch[0] != 2'd2; k++) step("seek2");
    en = 1'b0;
    for (int k = 0; k < 3; k++) step("hold");
    en = 1'b1;
    for (int k = 0; k < 4; k++) step("resume");

    // Mode toggle restarts the scan.
    mode = 1'b0;
    step("toggle_man");
    mode = 1'b1;
    for (int k = 0; k < 3; k++) step("toggle_scan");

    // Reset in the middle of a scan.
    for (int k = 0; k < 20 && e_ch[0] != 2'd3; k++) step("seek3");
    rst = 1'b1;
    step("rst_mid");
    rst = 1'b0;
    for (int k = 0; k < 4; k++) step("post_rst");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) mode = ~mode;
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < 4; k++) cha[k] = 4'($urandom);
        for (int k = 0; k < 3; k++) chb[k] = 4'($urandom);
      end
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
